mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_if.sv | 57 +++++
 rtl/mem_access_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl_if
// Purpose : groups the EXE/MEM inputs, MEM/WB outputs and the 16-bit SRAM bus
//           of the memory-stage access controller into one bundle.
// Signals : wb_en_in, mem_read_en_in, mem_write_en_in, alu_result_in,
//           val_rm_in, dst_in           - EXE/MEM register contents
//           freeze                      - pipeline stall request
//           wb_en_out, mem_read_en_out, alu_result_out, mem_data_out, dst_out
//                                       - MEM/WB register contents
//           sram_addr, sram_dq_out, sram_dq_in, sram_we_n
//                                       - external 16-bit SRAM port
// Modports: master - pipeline/SRAM side that feeds the controller
//           slave  - the controller itself
// -----------------------------------------------------------------------------
interface mem_access_ctrl_if;
  // EXE/MEM side
  logic        wb_en_in;
  logic        mem_read_en_in;
  logic        mem_write_en_in;
  logic [31:0] alu_result_in;
  logic [31:0] val_rm_in;
  logic [3:0]  dst_in;

  // stall
  logic        freeze;

  // MEM/WB side
  logic        wb_en_out;
  logic        mem_read_en_out;
  logic [31:0] alu_result_out;
  logic [31:0] mem_data_out;
  logic [3:0]  dst_out;

  // SRAM side
  logic [16:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;

  modport master (
    output wb_en_in, mem_read_en_in, mem_write_en_in,
    output alu_result_in, val_rm_in, dst_in,
    output sram_dq_in,
    input  freeze,
    input  wb_en_out, mem_read_en_out, alu_result_out, mem_data_out, dst_out,
    input  sram_addr, sram_dq_out, sram_we_n
  );

  modport slave (
    input  wb_en_in, mem_read_en_in, mem_write_en_in,
    input  alu_result_in, val_rm_in, dst_in,
    input  sram_dq_in,
    output freeze,
    output wb_en_out, mem_read_en_out, alu_result_out, mem_data_out, dst_out,
    output sram_addr, sram_dq_out, sram_we_n
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Purpose : memory stage of a 32-bit pipeline backed by a 16-bit SRAM. A load
//           or store is split into a low and a high half-word access, each
//           lasting WAIT_CYCLES clocks. While the access runs the controller
//           raises freeze so upstream stages and the EXE/MEM register hold,
//           and it feeds bubbles into MEM/WB. The completed instruction is
//           written into MEM/WB on the edge that leaves DONE.
// Ports   : clk  - single clock, rising edge
//           rst  - asynchronous, active-low reset
//           bus  - mem_access_ctrl_if.slave (EXE/MEM in, MEM/WB out, SRAM)
// Params  : WAIT_CYCLES - clocks per half-word access, legal 2..15
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_LO = 2'd1,
    ACC_HI = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Terminal value of the per-half wait counter.
  localparam logic [3:0] LP_LAST_CNT = 4'(WAIT_CYCLES - 32'd1);

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_cnt;
  logic [3:0]  w_next_cnt;

  logic        w_req;
  logic        w_is_read;
  logic        w_is_store;
  logic        w_last;

  logic        w_freeze;
  logic        w_sram_we_n;
  logic [16:0] w_sram_addr;
  logic [15:0] w_sram_dq_out;

  logic        r_wb_en;
  logic        r_mem_read_en;
  logic [31:0] r_alu_result;
  logic [31:0] r_mem_data;
  logic [3:0]  r_dst;
  logic [31:0] r_rd_data;

  assign w_req      = bus.mem_read_en_in | bus.mem_write_en_in;
  // A request with both enables set behaves as a load, so a store needs
  // the read enable low.
  assign w_is_read  = bus.mem_read_en_in;
  assign w_is_store = bus.mem_write_en_in & ~bus.mem_read_en_in;
  assign w_last     = (r_cnt == LP_LAST_CNT);

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Next-state logic plus stall and SRAM bus decode.
  always_comb begin
    w_next_state  = r_state;
    w_next_cnt    = r_cnt;
    w_freeze      = 1'b0;
    w_sram_we_n   = 1'b1;
    w_sram_addr   = 17'd0;
    w_sram_dq_out = 16'd0;

    case (r_state)
      IDLE: begin
        if (w_req) begin
          // Stall starts in the request cycle; the SRAM is not yet driven.
          w_freeze     = 1'b1;
          w_next_state = ACC_LO;
          w_next_cnt   = 4'd0;
        end else begin
          w_next_state = IDLE;
          w_next_cnt   = 4'd0;
        end
      end

      ACC_LO: begin
        w_freeze      = 1'b1;
        w_sram_addr   = {bus.alu_result_in[17:2], 1'b0};
        w_sram_dq_out = bus.val_rm_in[15:0];
        // Strobe drops in the final wait cycle to give the SRAM hold time.
        w_sram_we_n   = ~(w_is_store & ~w_last);
        if (w_last) begin
          w_next_cnt   = 4'd0;
          w_next_state = ACC_HI;
        end else begin
          w_next_cnt   = r_cnt + 4'd1;
        end
      end

      ACC_HI: begin
        w_freeze      = 1'b1;
        w_sram_addr   = {bus.alu_result_in[17:2], 1'b1};
        w_sram_dq_out = bus.val_rm_in[31:16];
        w_sram_we_n   = ~(w_is_store & ~w_last);
        if (w_last) begin
          w_next_cnt   = 4'd0;
          w_next_state = DONE;
        end else begin
          w_next_cnt   = r_cnt + 4'd1;
        end
      end

      DONE: begin
        w_next_state = IDLE;
        w_next_cnt   = 4'd0;
      end

      default: begin
        w_next_state = IDLE;
        w_next_cnt   = 4'd0;
      end
    endcase
  end

  // Capture of the two read half-words at the end of each half access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_data <= 32'd0;
    end else if (w_is_read && w_last && (r_state == ACC_LO)) begin
      r_rd_data[15:0] <= bus.sram_dq_in;
    end else if (w_is_read && w_last && (r_state == ACC_HI)) begin
      r_rd_data[31:16] <= bus.sram_dq_in;
    end else begin
      r_rd_data <= r_rd_data;
    end
  end

  // MEM/WB register: pass-through when idle, bubble while stalled,
  // completed instruction on the DONE edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_en       <= 1'b0;
      r_mem_read_en <= 1'b0;
      r_alu_result  <= 32'd0;
      r_mem_data    <= 32'd0;
      r_dst         <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_wb_en       <= 1'b0;
            r_mem_read_en <= 1'b0;
          end else begin
            r_wb_en       <= bus.wb_en_in;
            r_mem_read_en <= bus.mem_read_en_in;
            r_alu_result  <= bus.alu_result_in;
            r_dst         <= bus.dst_in;
          end
        end

        ACC_LO, ACC_HI: begin
          r_wb_en       <= 1'b0;
          r_mem_read_en <= 1'b0;
        end

        DONE: begin
          r_wb_en       <= bus.wb_en_in;
          r_mem_read_en <= bus.mem_read_en_in;
          r_alu_result  <= bus.alu_result_in;
          r_dst         <= bus.dst_in;
          if (w_is_read) begin
            r_mem_data <= r_rd_data;
          end else begin
            r_mem_data <= r_mem_data;
          end
        end

        default: begin
          r_wb_en       <= 1'b0;
          r_mem_read_en <= 1'b0;
        end
      endcase
    end
  end

  // The state register resets to IDLE asynchronously, but a request still
  // held on the inputs would otherwise keep freeze high during reset.
  assign bus.freeze          = rst & w_freeze;
  assign bus.sram_we_n       = w_sram_we_n;
  assign bus.sram_addr       = w_sram_addr;
  assign bus.sram_dq_out     = w_sram_dq_out;

  assign bus.wb_en_out       = r_wb_en;
  assign bus.mem_read_en_out = r_mem_read_en;
  assign bus.alu_result_out  = r_alu_result;
  assign bus.mem_data_out    = r_mem_data;
  assign bus.dst_out         = r_dst;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
// Directed bench for mem_access_ctrl. dut_a uses WAIT_CYCLES=2 with a small
// writable SRAM model; dut_b uses WAIT_CYCLES=3 with a fixed read-only SRAM.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

  logic clk;
  logic rst;

  logic        wb_in  [2];
  logic        rd_in  [2];
  logic        wr_in  [2];
  logic [31:0] alu_in [2];
  logic [31:0] val_in [2];
  logic [3:0]  dst_in [2];

  logic        frz_o  [2];
  logic        wbo    [2];
  logic        rdo    [2];
  logic        we_n_o [2];
  logic [31:0] alu_o  [2];
  logic [31:0] md_o   [2];
  logic [3:0]  dst_o  [2];
  logic [16:0] addr_o [2];
  logic [15:0] dq_o   [2];

  logic [15:0] mem_a [0:63] = '{default: 16'h0000};

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_ctrl_if bus_a ();
  mem_access_ctrl_if bus_b ();

  mem_access_ctrl #(.WAIT_CYCLES(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  mem_access_ctrl #(.WAIT_CYCLES(3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  assign bus_a.wb_en_in        = wb_in[0];
  assign bus_a.mem_read_en_in  = rd_in[0];
  assign bus_a.mem_write_en_in = wr_in[0];
  assign bus_a.alu_result_in   = alu_in[0];
  assign bus_a.val_rm_in       = val_in[0];
  assign bus_a.dst_in          = dst_in[0];
  assign bus_b.wb_en_in        = wb_in[1];
  assign bus_b.mem_read_en_in  = rd_in[1];
  assign bus_b.mem_write_en_in = wr_in[1];
  assign bus_b.alu_result_in   = alu_in[1];
  assign bus_b.val_rm_in       = val_in[1];
  assign bus_b.dst_in          = dst_in[1];

  assign frz_o[0]  = bus_a.freeze;          assign frz_o[1]  = bus_b.freeze;
  assign wbo[0]    = bus_a.wb_en_out;       assign wbo[1]    = bus_b.wb_en_out;
  assign rdo[0]    = bus_a.mem_read_en_out; assign rdo[1]    = bus_b.mem_read_en_out;
  assign we_n_o[0] = bus_a.sram_we_n;       assign we_n_o[1] = bus_b.sram_we_n;
  assign alu_o[0]  = bus_a.alu_result_out;  assign alu_o[1]  = bus_b.alu_result_out;
  assign md_o[0]   = bus_a.mem_data_out;    assign md_o[1]   = bus_b.mem_data_out;
  assign dst_o[0]  = bus_a.dst_out;         assign dst_o[1]  = bus_b.dst_out;
  assign addr_o[0] = bus_a.sram_addr;       assign addr_o[1] = bus_b.sram_addr;
  assign dq_o[0]   = bus_a.sram_dq_out;     assign dq_o[1]   = bus_b.sram_dq_out;

  // SRAM models: dut_a reads/writes mem_a, dut_b sees fixed data at 8 and 9.
  assign bus_a.sram_dq_in = mem_a[bus_a.sram_addr[5:0]];
  assign bus_b.sram_dq_in = (bus_b.sram_addr == 17'd8) ? 16'h1234 :
                            (bus_b.sram_addr == 17'd9) ? 16'h5678 : 16'h0000;

  // Synchronous write port of the dut_a SRAM model.
  always @(posedge clk) begin
    if (!bus_a.sram_we_n) mem_a[bus_a.sram_addr[5:0]] <= bus_a.sram_dq_out;
  end

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int idx, input logic rd, input logic wr, input logic wbe,
                        input logic [31:0] alu, input logic [31:0] val, input logic [3:0] dst);
    rd_in[idx]  = rd;
    wr_in[idx]  = wr;
    wb_in[idx]  = wbe;
    alu_in[idx] = alu;
    val_in[idx] = val;
    dst_in[idx] = dst;
  endtask

  // Starts an access at a negedge and follows it through the DONE edge.
  // Returns on the negedge after the DONE edge with inputs still applied.
  task automatic run_access(input int idx, input logic rd, input logic wr, input logic wbe,
                            input logic [31:0] alu, input logic [31:0] val, input logic [3:0] dst,
                            output int frz, output int we_lo_lo, output int we_lo_hi,
                            output int bub, output int tmo,
                            output logic [16:0] a_lo, output logic [16:0] a_hi,
                            output logic [15:0] d_lo, output logic [15:0] d_hi);
    int  w;
    logic done_f;
    w = (idx == 0) ? 2 : 3;
    frz = 0; we_lo_lo = 0; we_lo_hi = 0; bub = 0; tmo = 0;
    a_lo = '0; a_hi = '0; d_lo = '0; d_hi = '0;
    done_f = 1'b0;
    set_in(idx, rd, wr, wbe, alu, val, dst);
    for (int c = 0; c < 40 && !done_f; c++) begin
      #1;
      if (c > 0 && (wbo[idx] || rdo[idx])) bub++;
      if (!frz_o[idx]) begin
        done_f = 1'b1;
      end else begin
        frz++;
        if (!we_n_o[idx] && c >= 1 && c <= w) we_lo_lo++;
        if (!we_n_o[idx] && c > w) we_lo_hi++;
        if (c == 1) begin a_lo = addr_o[idx]; d_lo = dq_o[idx]; end
        if (c == 1 + w) begin a_hi = addr_o[idx]; d_hi = dq_o[idx]; end
      end
      @(negedge clk);
    end
    if (!done_f) tmo = 1;
  endtask

  int          frz, wl_lo, wl_hi, bub, tmo;
  logic [16:0] a_lo, a_hi;
  logic [15:0] d_lo, d_hi;

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 2; i++) set_in(i, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);

    // Reset state.
    @(negedge clk); #1;
    check_val("rst_freeze", frz_o[0], 1'b0);
    check_val("rst_we_n",   we_n_o[0], 1'b1);
    check_val("rst_addr",   addr_o[0], 17'd0);
    check_val("rst_dq",     dq_o[0], 16'd0);
    check_val("rst_wb",     wbo[0], 1'b0);
    check_val("rst_alu",    alu_o[0], 32'd0);
    check_val("rst_md",     md_o[0], 32'd0);
    check_val("rst_dst",    dst_o[0], 4'd0);
    rst = 1'b1;

    // Plain ALU instruction passes straight through.
    set_in(0, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'd0, 4'd5);
    #1 check_val("alu_freeze_now", frz_o[0], 1'b0);
    @(negedge clk); #1;
    check_val("alu_wb",     wbo[0], 1'b1);
    check_val("alu_dst",    dst_o[0], 4'd5);
    check_val("alu_res",    alu_o[0], 32'h0000_0010);
    check_val("alu_freeze", frz_o[0], 1'b0);

    // Store 0xDEADBEEF to byte address 8.
    run_access(0, 1'b0, 1'b1, 1'b0, 32'h0000_0008, 32'hDEAD_BEEF, 4'd3,
               frz, wl_lo, wl_hi, bub, tmo, a_lo, a_hi, d_lo, d_hi);
    #1;
    check_val("st_tmo",     tmo, 0);
    check_val("st_frz",     frz, 5);
    check_val("st_we_lo",   wl_lo, 1);
    check_val("st_we_hi",   wl_hi, 1);
    check_val("st_addr_lo", a_lo, 17'h00004);
    check_val("st_dq_lo",   d_lo, 16'hBEEF);
    check_val("st_addr_hi", a_hi, 17'h00005);
    check_val("st_dq_hi",   d_hi, 16'hDEAD);
    check_val("st_bubble",  bub, 0);
    check_val("st_mem4",    mem_a[4], 16'hBEEF);
    check_val("st_mem5",    mem_a[5], 16'hDEAD);
    check_val("st_md_hold", md_o[0], 32'd0);
    check_val("st_wb",      wbo[0], 1'b0);
    check_val("st_dst",     dst_o[0], 4'd3);
    check_val("st_alu",     alu_o[0], 32'h0000_0008);

    // Load back from the same address.
    run_access(0, 1'b1, 1'b0, 1'b1, 32'h0000_0008, 32'd0, 4'd7,
               frz, wl_lo, wl_hi, bub, tmo, a_lo, a_hi, d_lo, d_hi);
    #1;
    check_val("ld_tmo",    tmo, 0);
    check_val("ld_frz",    frz, 5);
    check_val("ld_we",     wl_lo + wl_hi, 0);
    check_val("ld_bubble", bub, 0);
    check_val("ld_md",     md_o[0], 32'hDEAD_BEEF);
    check_val("ld_rd",     rdo[0], 1'b1);
    check_val("ld_wb",     wbo[0], 1'b1);
    check_val("ld_dst",    dst_o[0], 4'd7);

    // Back-to-back store right after the load's DONE.
    run_access(0, 1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h0102_0304, 4'd1,
               frz, wl_lo, wl_hi, bub, tmo, a_lo, a_hi, d_lo, d_hi);
    #1;
    check_val("b2b_tmo",     tmo, 0);
    check_val("b2b_frz",     frz, 5);
    check_val("b2b_addr_lo", a_lo, 17'h00010);
    check_val("b2b_mem10",   mem_a[16], 16'h0304);
    check_val("b2b_mem11",   mem_a[17], 16'h0102);
    check_val("b2b_md_hold", md_o[0], 32'hDEAD_BEEF);

    // ALU op afterwards leaves mem_data_out untouched.
    set_in(0, 1'b0, 1'b0, 1'b1, 32'h0000_0055, 32'd0, 4'd9);
    @(negedge clk); #1;
    check_val("alu2_res",  alu_o[0], 32'h0000_0055);
    check_val("alu2_md",   md_o[0], 32'hDEAD_BEEF);

    // Reset in ACC_HI of a store aborts it.
    set_in(0, 1'b0, 1'b1, 1'b0, 32'h0000_0030, 32'hAAAA_5555, 4'd1);
    repeat (3) @(negedge clk);
    #1;
    check_val("abort_pre_we",   we_n_o[0], 1'b0);
    check_val("abort_pre_addr", addr_o[0], 17'h00019);
    rst = 1'b0;
    #1;
    check_val("abort_freeze", frz_o[0], 1'b0);
    check_val("abort_we_n",   we_n_o[0], 1'b1);
    check_val("abort_addr",   addr_o[0], 17'd0);
    check_val("abort_md",     md_o[0], 32'd0);
    check_val("abort_alu",    alu_o[0], 32'd0);
    check_val("abort_dst",    dst_o[0], 4'd0);
    set_in(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge clk); #1;
    check_val("abort_mem18", mem_a[24], 16'h5555);
    check_val("abort_mem19", mem_a[25], 16'h0000);
    rst = 1'b1;
    set_in(0, 1'b0, 1'b0, 1'b1, 32'h0000_0077, 32'd0, 4'd2);
    @(negedge clk); #1;
    check_val("resume_wb",  wbo[0], 1'b1);
    check_val("resume_alu", alu_o[0], 32'h0000_0077);
    check_val("resume_dst", dst_o[0], 4'd2);

    // Both enables set on the WAIT_CYCLES=3 instance: a load, no write.
    run_access(1, 1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'hFFFF_0000, 4'd4,
               frz, wl_lo, wl_hi, bub, tmo, a_lo, a_hi, d_lo, d_hi);
    #1;
    check_val("rw_tmo",     tmo, 0);
    check_val("rw_frz",     frz, 7);
    check_val("rw_we",      wl_lo + wl_hi, 0);
    check_val("rw_bubble",  bub, 0);
    check_val("rw_addr_lo", a_lo, 17'h00008);
    check_val("rw_addr_hi", a_hi, 17'h00009);
    check_val("rw_md",      md_o[1], 32'h5678_1234);
    check_val("rw_rd",      rdo[1], 1'b1);
    check_val("rw_wb",      wbo[1], 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
